// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: decides on which in_clk cycles the CPU core advances.
// Supports free-run at 1/1, 1/2, 1/4 or 1/8 rate, single-step from a
// debounced push button, and a halt request from the core. Also counts
// every enable pulse it issues.
module cpu_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 in_clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [1:0]           div_sel,
  input  logic                 step_btn,
  input  logic                 halt,
  output logic                 cpu_en,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [1:0]           state
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t          cur_state;
  logic            sync_a;
  logic            sync_b;
  logic            db_level;
  logic            db_level_d;
  logic [DB_W-1:0] db_cnt;
  logic [2:0]      prescaler;
  logic [2:0]      mask;
  logic            tick;
  logic            step_req;
  logic            take_step;
  logic            run_pulse;

  // Two-flop synchronizer bringing the raw button into the in_clk domain
  always_ff @(posedge in_clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= step_btn;
      sync_b <= sync_a;
    end
  end

  // Debounce: the accepted level only flips after DEBOUNCE_CYCLES differing samples in a row
  always_ff @(posedge in_clk) begin
    if (rst) begin
      db_level   <= 1'b0;
      db_level_d <= 1'b0;
      db_cnt     <= '0;
    end else begin
      db_level_d <= db_level;
      if (sync_b != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= sync_b;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // A press is one cycle long: the rising edge of the debounced level
  assign step_req = db_level & ~db_level_d;

  // Rate mask: a tick whenever the low prescaler bits selected by div_sel are all zero
  always_comb begin
    mask = 3'b000;
    case (div_sel)
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
  end

  assign tick      = (prescaler & mask) == 3'd0;
  assign take_step = (cur_state == IDLE) && !halt && !run && step_req;
  assign run_pulse = (cur_state == RUN) && run && !halt && tick;

  // Prescaler runs only in RUN so every entry into RUN starts with a tick
  always_ff @(posedge in_clk) begin
    if (rst || (cur_state != RUN)) begin
      prescaler <= 3'd0;
    end else begin
      prescaler <= prescaler + 3'd1;
    end
  end

  // Mode FSM with the registered enable; halt beats run, run beats a step press
  always_ff @(posedge in_clk) begin
    if (rst) begin
      cur_state <= IDLE;
      cpu_en    <= 1'b0;
    end else begin
      cpu_en <= run_pulse || take_step;
      case (cur_state)
        IDLE: begin
          if (halt) begin
            cur_state <= HALTED;
          end else if (run) begin
            cur_state <= RUN;
          end else if (step_req) begin
            cur_state <= STEP;
          end
        end
        RUN: begin
          if (halt) begin
            cur_state <= HALTED;
          end else if (!run) begin
            cur_state <= IDLE;
          end
        end
        STEP: begin
          cur_state <= IDLE;
        end
        HALTED: begin
          if (!halt) begin
            cur_state <= IDLE;
          end
        end
        default: begin
          cur_state <= IDLE;
        end
      endcase
    end
  end

  // Count every enable pulse handed to the core, wrapping naturally
  always_ff @(posedge in_clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
    end
  end

  assign state = cur_state;

endmodule
